// File: rtl/z16_instr_mem_sync_if.sv
// Fetch/program-load bus between the Z16 fetch logic and the instruction memory.
// Z16_IMEM_PARITY_EN adds the o_parity_err response signal.
interface z16_instr_mem_sync_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_stall;
  logic [DATA_W-1:0] o_instr;
  logic              o_valid;
  logic              o_err;
  logic              o_busy;
  logic              i_we;
  logic [ADDR_W-1:0] i_waddr;
  logic [DATA_W-1:0] i_wdata;
`ifdef Z16_IMEM_PARITY_EN
  logic              o_parity_err;

  modport master (
    output i_req, i_addr, i_stall, i_we, i_waddr, i_wdata,
    input  o_instr, o_valid, o_err, o_busy, o_parity_err
  );

  modport slave (
    input  i_req, i_addr, i_stall, i_we, i_waddr, i_wdata,
    output o_instr, o_valid, o_err, o_busy, o_parity_err
  );
`else
  modport master (
    output i_req, i_addr, i_stall, i_we, i_waddr, i_wdata,
    input  o_instr, o_valid, o_err, o_busy
  );

  modport slave (
    input  i_req, i_addr, i_stall, i_we, i_waddr, i_wdata,
    output o_instr, o_valid, o_err, o_busy
  );
`endif
endinterface

// File: rtl/z16_instr_mem_sync.sv
// Z16 synchronous instruction memory: clear sweep after reset, registered fetch with stall hold,
// program-load write port. Optional per-word even parity when Z16_IMEM_PARITY_EN is defined.
module z16_instr_mem_sync #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DEPTH     = 32,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic                 i_clk,
  input logic                 i_rst,
  z16_instr_mem_sync_if.slave bus
);

  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy;
  logic              accept;

  logic [ADDR_W-1:0] rd_idx_a;
  logic [ADDR_W-1:0] wr_idx_a;
  logic              rd_in_range;
  logic              wr_in_range;
  logic              rd_err;
  logic [DATA_W-1:0] rd_word;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic              unused_waddr_lsb;

  // Word indices zero-extended to the full address width so DEPTH == 2**(ADDR_W-1) still compares correctly.
  assign rd_idx_a         = {1'b0, bus.i_addr[ADDR_W-1:1]};
  assign wr_idx_a         = {1'b0, bus.i_waddr[ADDR_W-1:1]};
  assign rd_in_range      = (rd_idx_a < DEPTH_A);
  assign wr_in_range      = (wr_idx_a < DEPTH_A);
  assign rd_err           = bus.i_addr[0] | ~rd_in_range;
  assign rd_word          = mem_q[rd_idx_a[IDX_W-1:0]];
  assign unused_waddr_lsb = bus.i_waddr[0];

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_RUN: state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  // Output logic
  always_comb begin
    busy   = (state_q == ST_CLEAR);
    accept = ~busy & bus.i_req & ~bus.i_stall;
  end

  // Memory write port: the clear sweep owns it in CLEAR, program load in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = cnt_q;
    mem_wdata = CLEAR_VAL;
    if (!i_rst) begin
      if (state_q == ST_CLEAR) begin
        mem_we = 1'b1;
      end else if (bus.i_we && wr_in_range) begin
        mem_we    = 1'b1;
        mem_widx  = wr_idx_a[IDX_W-1:0];
        mem_wdata = bus.i_wdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  // Read response: stall freezes everything, otherwise valid follows the previous accept.
  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (!bus.i_stall) begin
      valid_d = accept;
      err_d   = accept & rd_err;
      if (accept) begin
        instr_d = rd_err ? CLEAR_VAL : rd_word;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_q <= CLEAR_VAL;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_instr = instr_q;
  assign bus.o_valid = valid_q;
  assign bus.o_err   = err_q;
  assign bus.o_busy  = busy;

`ifdef Z16_IMEM_PARITY_EN
  logic mem_par_q [DEPTH];
  logic parity_err_q, parity_err_d;
  logic rd_par;

  assign rd_par = mem_par_q[rd_idx_a[IDX_W-1:0]];

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_par_q[mem_widx] <= ^mem_wdata;
    end
  end

  // Address errors take precedence; parity is only judged on a real word.
  always_comb begin
    parity_err_d = parity_err_q;
    if (!bus.i_stall) begin
      parity_err_d = accept & ~rd_err & ((^rd_word) != rd_par);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_z16_instr_mem_sync.sv
// Directed self-checking bench for z16_instr_mem_sync (DEPTH=32, CLEAR_VAL=0).
module tb_z16_instr_mem_sync;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  z16_instr_mem_sync_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  z16_instr_mem_sync #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .DEPTH    (32),
    .CLEAR_VAL(16'h0000)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle; inputs are changed and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (bus.o_busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", bus.o_busy); end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.o_err); end
    total++; if (bus.o_instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h exp=0000", bus.o_instr); end
    measure_busy(n);
    total++; if (n != 32) begin bad++; $display("FAIL reset_busy_cycles got=%0d exp=32", n); end
  endtask

  task automatic test_clear_reads();
    for (int i = 0; i < 32; i++) begin
      bus.i_req  = 1'b1;
      bus.i_addr = 16'(2 * i);
      step();
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_err !== 1'b0 || bus.o_instr !== 16'h0000) begin
        bad++;
        $display("FAIL clear_read idx=%0d got v=%b e=%b d=%h exp v=1 e=0 d=0000", i, bus.o_valid, bus.o_err, bus.o_instr);
      end
    end
    bus.i_req = 1'b0;
    step();
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", bus.o_valid); end
  endtask

  task automatic test_write_fetch();
    bus.i_we = 1'b1; bus.i_waddr = 16'h0000; bus.i_wdata = 16'h406A;
    step();
    bus.i_waddr = 16'h0006; bus.i_wdata = 16'h008A;
    step();
    bus.i_we = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 16'h0000;
    step();
    total++; if (bus.o_valid !== 1'b1 || bus.o_err !== 1'b0 || bus.o_instr !== 16'h406A) begin
      bad++; $display("FAIL b2b_first got v=%b e=%b d=%h exp v=1 e=0 d=406a", bus.o_valid, bus.o_err, bus.o_instr); end
    bus.i_addr = 16'h0006;
    step();
    total++; if (bus.o_valid !== 1'b1 || bus.o_err !== 1'b0 || bus.o_instr !== 16'h008A) begin
      bad++; $display("FAIL b2b_second got v=%b e=%b d=%h exp v=1 e=0 d=008a", bus.o_valid, bus.o_err, bus.o_instr); end
    bus.i_req = 1'b0;
    step();
    total++; if (bus.o_valid !== 1'b0 || bus.o_instr !== 16'h008A) begin
      bad++; $display("FAIL idle_hold_instr got v=%b d=%h exp v=0 d=008a", bus.o_valid, bus.o_instr); end
  endtask

  task automatic test_errors();
    logic [15:0] addrs [4];
    logic        errs  [4];
    addrs = '{16'h0003, 16'h0040, 16'h003E, 16'hFFFE};
    errs  = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      bus.i_req  = 1'b1;
      bus.i_addr = addrs[i];
      step();
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_err !== errs[i] || bus.o_instr !== 16'h0000) begin
        bad++;
        $display("FAIL err_addr a=%h got v=%b e=%b d=%h exp v=1 e=%b d=0000", addrs[i], bus.o_valid, bus.o_err, bus.o_instr, errs[i]);
      end
    end
    bus.i_req = 1'b0;
    step();
    total++; if (bus.o_valid !== 1'b0 || bus.o_err !== 1'b0) begin
      bad++; $display("FAIL err_clear got v=%b e=%b exp v=0 e=0", bus.o_valid, bus.o_err); end
  endtask

  task automatic test_stall();
    bus.i_req = 1'b1; bus.i_addr = 16'h0000;
    step();
    total++; if (bus.o_valid !== 1'b1 || bus.o_instr !== 16'h406A) begin
      bad++; $display("FAIL stall_pre got v=%b d=%h exp v=1 d=406a", bus.o_valid, bus.o_instr); end
    bus.i_stall = 1'b1; bus.i_addr = 16'h0006;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_err !== 1'b0 || bus.o_instr !== 16'h406A) begin
        bad++; $display("FAIL stall_hold cyc=%0d got v=%b e=%b d=%h exp v=1 e=0 d=406a", i, bus.o_valid, bus.o_err, bus.o_instr);
      end
    end
    bus.i_stall = 1'b0; bus.i_req = 1'b0;
    step();
    total++; if (bus.o_valid !== 1'b0 || bus.o_instr !== 16'h406A) begin
      bad++; $display("FAIL stall_dropped got v=%b d=%h exp v=0 d=406a", bus.o_valid, bus.o_instr); end
    bus.i_req = 1'b1; bus.i_addr = 16'h0003;
    step();
    bus.i_stall = 1'b1; bus.i_addr = 16'h0000;
    step();
    total++; if (bus.o_valid !== 1'b1 || bus.o_err !== 1'b1 || bus.o_instr !== 16'h0000) begin
      bad++; $display("FAIL stall_err_hold got v=%b e=%b d=%h exp v=1 e=1 d=0000", bus.o_valid, bus.o_err, bus.o_instr); end
    bus.i_stall = 1'b0; bus.i_req = 1'b0;
    step();
    bus.i_stall = 1'b1; bus.i_req = 1'b1; bus.i_addr = 16'h0000;
    step();
    total++; if (bus.o_valid !== 1'b0 || bus.o_err !== 1'b0) begin
      bad++; $display("FAIL stall_idle got v=%b e=%b exp v=0 e=0", bus.o_valid, bus.o_err); end
    bus.i_we = 1'b1; bus.i_waddr = 16'h0008; bus.i_wdata = 16'hBEEF;
    step();
    bus.i_we = 1'b0; bus.i_stall = 1'b0; bus.i_addr = 16'h0008;
    step();
    total++; if (bus.o_valid !== 1'b1 || bus.o_instr !== 16'hBEEF) begin
      bad++; $display("FAIL write_in_stall got v=%b d=%h exp v=1 d=beef", bus.o_valid, bus.o_instr); end
    bus.i_req = 1'b0;
    step();
  endtask

  task automatic test_read_write_same();
    bus.i_we = 1'b1; bus.i_waddr = 16'h0002; bus.i_wdata = 16'h1234;
    bus.i_req = 1'b1; bus.i_addr = 16'h0002;
    step();
    total++; if (bus.o_valid !== 1'b1 || bus.o_instr !== 16'h0000) begin
      bad++; $display("FAIL rw_old got v=%b d=%h exp v=1 d=0000", bus.o_valid, bus.o_instr); end
    bus.i_we = 1'b0;
    step();
    total++; if (bus.o_valid !== 1'b1 || bus.o_instr !== 16'h1234) begin
      bad++; $display("FAIL rw_new got v=%b d=%h exp v=1 d=1234", bus.o_valid, bus.o_instr); end
    bus.i_req = 1'b0;
    bus.i_we = 1'b1; bus.i_waddr = 16'h0040; bus.i_wdata = 16'h5555;
    step();
    bus.i_waddr = 16'h0005; bus.i_wdata = 16'h7777;
    step();
    bus.i_we = 1'b0; bus.i_req = 1'b1; bus.i_addr = 16'h0000;
    step();
    total++; if (bus.o_instr !== 16'h406A) begin
      bad++; $display("FAIL oor_write_alias got=%h exp=406a", bus.o_instr); end
    bus.i_addr = 16'h0004;
    step();
    total++; if (bus.o_instr !== 16'h7777) begin
      bad++; $display("FAIL waddr_lsb_ignored got=%h exp=7777", bus.o_instr); end
    bus.i_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 16'h0000;
    bus.i_we = 1'b1; bus.i_waddr = 16'h0000; bus.i_wdata = 16'hAAAA;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (bus.o_busy !== 1'b1 || bus.o_valid !== 1'b0) begin
        bad++; $display("FAIL sweep_ignore cyc=%0d got busy=%b v=%b exp busy=1 v=0", i, bus.o_busy, bus.o_valid);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.o_busy !== 1'b1 || bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL midsweep_reset got busy=%b v=%b exp busy=1 v=0", bus.o_busy, bus.o_valid); end
    measure_busy(n);
    total++; if (n != 32) begin bad++; $display("FAIL midsweep_busy_cycles got=%0d exp=32", n); end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL sweep_end_valid got=%b exp=0", bus.o_valid); end
    bus.i_we = 1'b0; bus.i_req = 1'b0;
    step();
    bus.i_req = 1'b1; bus.i_addr = 16'h0000;
    rst = 1'b1;
    step();
    rst = 1'b0; bus.i_req = 1'b0;
    total++; if (bus.o_busy !== 1'b1 || bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL midfetch_reset got busy=%b v=%b exp busy=1 v=0", bus.o_busy, bus.o_valid); end
    measure_busy(n);
    total++; if (n != 32) begin bad++; $display("FAIL midfetch_busy_cycles got=%0d exp=32", n); end
    for (int i = 0; i < 32; i++) begin
      bus.i_req = 1'b1; bus.i_addr = 16'(2 * i);
      step();
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_instr !== 16'h0000) begin
        bad++; $display("FAIL recleared idx=%0d got v=%b d=%h exp v=1 d=0000", i, bus.o_valid, bus.o_instr);
      end
    end
    bus.i_req = 1'b0;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.i_stall = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_waddr = '0;
    bus.i_wdata = '0;
    step();
    test_reset();
    test_clear_reads();
    test_write_fetch();
    test_errors();
    test_stall();
    test_read_write_same();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
